// File: rtl/count_down_timer_if.sv
// Level/timebase inputs and display/done outputs of the countdown timer.
// master drives stimulus and observes the display; slave is the timer.
interface count_down_timer_if;
  logic       Clk1Hz;
  logic [3:0] curLevel;
  logic       start;
  logic       doneCounting;
  logic [7:0] seg0;
  logic [7:0] seg1;

  modport master (
    output Clk1Hz, curLevel, start,
    input  doneCounting, seg0, seg1
  );

  modport slave (
    input  Clk1Hz, curLevel, start,
    output doneCounting, seg0, seg1
  );
endinterface

// File: rtl/count_down_timer.sv
// Level countdown: loads 10+curLevel on a start edge, decrements once per synced 1 Hz tick.
// Display and done pulse update on the same edge that changes the count; no backpressure.
module count_down_timer (
  input  logic             Clk100M,
  input  logic             Reset,
  count_down_timer_if.slave tmr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [4:0] count;
  logic       sync1, sync2, syncPrev;
  logic       startPrev, startHeld;
  logic       doneQ;
  logic [7:0] seg0Q, seg1Q;

  logic       tick, startEdge;
  logic [1:0] nextState;
  logic [4:0] nextCount;
  logic       nextDone;
  logic [3:0] tens, ones;
  logic [7:0] nextSeg0, nextSeg1;

  function automatic logic [7:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 8'hC0;
      4'd1:    segCode = 8'hF9;
      4'd2:    segCode = 8'hA4;
      4'd3:    segCode = 8'hB0;
      4'd4:    segCode = 8'h99;
      4'd5:    segCode = 8'h92;
      4'd6:    segCode = 8'h82;
      4'd7:    segCode = 8'hF8;
      4'd8:    segCode = 8'h80;
      4'd9:    segCode = 8'h90;
      default: segCode = 8'hFF;
    endcase
  endfunction

  assign tick = sync2 & ~syncPrev;
  // startHeld masks a start level that was already high while in reset
  assign startEdge = tmr.start & ~startPrev & ~startHeld;

  always_comb begin
    nextState = state;
    nextCount = count;
    nextDone  = 1'b0;
    if (startEdge) begin
      nextState = RUN;
      nextCount = 5'd10 + {1'b0, tmr.curLevel};
    end else if (tick && state == RUN && count != 5'd0) begin
      nextCount = count - 5'd1;
      if (count == 5'd1) begin
        nextState = DONE;
        nextDone  = 1'b1;
      end
    end
  end

  always_comb begin
    tens = 4'd0;
    ones = nextCount[3:0];
    if (nextCount >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(nextCount - 5'd20);
    end else if (nextCount >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(nextCount - 5'd10);
    end
    nextSeg0 = 8'hFF;
    nextSeg1 = 8'hFF;
    if (nextState != IDLE) begin
      nextSeg0 = segCode(ones);
      nextSeg1 = segCode(tens);
    end
  end

  // Outputs are registered from next-state so the display tracks count with no extra lag
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= 5'd0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      syncPrev  <= 1'b0;
      startPrev <= 1'b0;
      startHeld <= tmr.start;
      doneQ     <= 1'b0;
      seg0Q     <= 8'hFF;
      seg1Q     <= 8'hFF;
    end else begin
      sync1     <= tmr.Clk1Hz;
      sync2     <= sync1;
      syncPrev  <= sync2;
      startPrev <= tmr.start;
      if (!tmr.start) startHeld <= 1'b0;
      state     <= nextState;
      count     <= nextCount;
      doneQ     <= nextDone;
      seg0Q     <= nextSeg0;
      seg1Q     <= nextSeg1;
    end
  end

  assign tmr.doneCounting = doneQ;
  assign tmr.seg0         = seg0Q;
  assign tmr.seg1         = seg1Q;

endmodule

// File: tb/tb_count_down_timer.sv
// Directed bench for count_down_timer: cycle-level reference model compared every cycle,
// plus hand-computed display/pulse expectations at key points.
module tb_count_down_timer;

  logic Clk100M = 1'b0;
  logic Reset;
  count_down_timer_if tmr ();

  count_down_timer dut (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .tmr     (tmr.slave)
  );

  always #5 Clk100M = ~Clk100M;

  int passCnt = 0;
  int totalCnt = 0;
  int dutDoneCnt = 0;
  bit chkOn = 1'b0;

  logic [7:0] segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model: mState 0=idle 1=run 2=done
  int mState = 0;
  int mCount = 0;
  bit mDone = 1'b0;
  bit mPrevSt = 1'b0;
  bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] expSeg(input int cnt, input int st, input bit tensDigit);
    if (st == 0) return 8'hFF;
    return tensDigit ? segTab[cnt / 10] : segTab[cnt % 10];
  endfunction

  always @(posedge Clk100M) begin
    bit tk, ed;
    h3 = h2; h2 = h1; h1 = h0; h0 = tmr.Clk1Hz;
    tk = h2 && !h3;
    ed = tmr.start && !mPrevSt;
    mPrevSt = tmr.start;
    mDone = 1'b0;
    if (Reset) begin
      mState = 0;
      mCount = 0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else if (ed) begin
      mState = 1;
      mCount = 10 + int'(tmr.curLevel);
    end else if (tk && mState == 1) begin
      mCount = mCount - 1;
      if (mCount == 0) begin
        mState = 2;
        mDone = 1'b1;
      end
    end
  end

  always @(negedge Clk100M) begin
    if (chkOn) begin
      chk("model_seg0", tmr.seg0, expSeg(mCount, mState, 1'b0));
      chk("model_seg1", tmr.seg1, expSeg(mCount, mState, 1'b1));
      chk("model_done", {7'd0, tmr.doneCounting}, {7'd0, mDone});
      if (tmr.doneCounting === 1'b1) dutDoneCnt++;
    end
  end

  task automatic doTick();
    tmr.Clk1Hz = 1'b1;
    repeat (3) @(negedge Clk100M);
    tmr.Clk1Hz = 1'b0;
    repeat (3) @(negedge Clk100M);
  endtask

  task automatic pulseStart(input logic [3:0] lvl);
    tmr.curLevel = lvl;
    tmr.start = 1'b1;
    @(negedge Clk100M);
    tmr.start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    tmr.Clk1Hz = 1'b0;
    tmr.start = 1'b0;
    tmr.curLevel = 4'd0;
    @(negedge Clk100M);
    chkOn = 1'b1;
    @(negedge Clk100M);
    chk("rst_done", {7'd0, tmr.doneCounting}, 8'h00);
    chk("rst_seg0", tmr.seg0, 8'hFF);
    chk("rst_seg1", tmr.seg1, 8'hFF);
    Reset = 1'b0;
    repeat (10) @(negedge Clk100M);
    chk("idle_seg0", tmr.seg0, 8'hFF);
    chk("idle_seg1", tmr.seg1, 8'hFF);

    // Level 0: "10" down to "00"
    pulseStart(4'd0);
    chk("load10_seg1", tmr.seg1, 8'hF9);
    chk("load10_seg0", tmr.seg0, 8'hC0);
    doTick();
    chk("cnt9_seg1", tmr.seg1, 8'hC0);
    chk("cnt9_seg0", tmr.seg0, 8'h90);
    for (int i = 0; i < 9; i++) doTick();
    chk("done_seg1", tmr.seg1, 8'hC0);
    chk("done_seg0", tmr.seg0, 8'hC0);
    chk("done_pulses", 8'(dutDoneCnt), 8'd1);
    doTick();
    doTick();
    chk("done_hold_seg0", tmr.seg0, 8'hC0);
    chk("done_hold_pulses", 8'(dutDoneCnt), 8'd1);

    // Level 15 with start held high, ticks still count
    tmr.curLevel = 4'd15;
    tmr.start = 1'b1;
    @(negedge Clk100M);
    chk("load25_seg1", tmr.seg1, 8'hA4);
    chk("load25_seg0", tmr.seg0, 8'h92);
    tmr.curLevel = 4'd5;
    doTick();
    doTick();
    repeat (87) @(negedge Clk100M);
    tmr.start = 1'b0;
    @(negedge Clk100M);
    chk("held23_seg1", tmr.seg1, 8'hA4);
    chk("held23_seg0", tmr.seg0, 8'hB0);

    // Start edge coinciding with a tick at count 7
    pulseStart(4'd0);
    for (int i = 0; i < 3; i++) doTick();
    chk("cnt7_seg0", tmr.seg0, 8'hF8);
    tmr.Clk1Hz = 1'b1;
    @(negedge Clk100M);
    @(negedge Clk100M);
    tmr.curLevel = 4'd3;
    tmr.start = 1'b1;
    @(negedge Clk100M);
    tmr.start = 1'b0;
    chk("restart13_seg1", tmr.seg1, 8'hF9);
    chk("restart13_seg0", tmr.seg0, 8'hB0);
    tmr.Clk1Hz = 1'b0;
    repeat (3) @(negedge Clk100M);
    chk("restart13_hold", tmr.seg0, 8'hB0);
    chk("restart_pulses", 8'(dutDoneCnt), 8'd1);

    // Reset at count 4 aborts silently
    for (int i = 0; i < 9; i++) doTick();
    chk("cnt4_seg1", tmr.seg1, 8'hC0);
    chk("cnt4_seg0", tmr.seg0, 8'h99);
    Reset = 1'b1;
    @(negedge Clk100M);
    Reset = 1'b0;
    chk("abort_seg0", tmr.seg0, 8'hFF);
    chk("abort_seg1", tmr.seg1, 8'hFF);
    for (int i = 0; i < 5; i++) doTick();
    chk("abort_idle_seg0", tmr.seg0, 8'hFF);
    chk("abort_pulses", 8'(dutDoneCnt), 8'd1);

    // start high across reset release must not load
    tmr.start = 1'b1;
    Reset = 1'b1;
    repeat (2) @(negedge Clk100M);
    Reset = 1'b0;
    repeat (5) @(negedge Clk100M);
    chk("heldrst_seg0", tmr.seg0, 8'hFF);
    tmr.start = 1'b0;
    @(negedge Clk100M);
    tmr.start = 1'b1;
    @(negedge Clk100M);
    chk("fresh_seg1", tmr.seg1, 8'hF9);
    chk("fresh_seg0", tmr.seg0, 8'hB0);
    tmr.start = 1'b0;
    repeat (3) @(negedge Clk100M);

    chkOn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
